// File: rtl/branch_sequencer.sv
// branch_sequencer: resolves conditional branches by borrowing the shared ALU,
// first for the compare and then, if taken, for the pc+imm target add. The
// result is a single-cycle PC redirect (pcLoad) with a flush on taken branches.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters with a synchronous clear (statsClr).
module branch_sequencer #(
   parameter int N      = 32,
   parameter int PC_INC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         brValid,
   output logic         brReady,
   input  logic [2:0]   funct3,
   input  logic [N-1:0] rs1Val,
   input  logic [N-1:0] rs2Val,
   input  logic [N-1:0] pcIn,
   input  logic [N-1:0] immIn,
   output logic         aluReq,
   input  logic         aluGnt,
   output logic [1:0]   aluOp,
   output logic [N-1:0] aluOpA,
   output logic [N-1:0] aluOpB,
   input  logic [N-1:0] aluOut,
   input  logic         aluEqual,
`ifdef BRANCH_STATS_EN
   input  logic         statsClr,
   output logic [31:0]  brTakenCnt,
   output logic [31:0]  brNotTakenCnt,
`endif
   output logic         pcLoad,
   output logic [N-1:0] pcNext,
   output logic         taken,
   output logic         flush,
   output logic         brIllegal
);

   typedef enum logic [1:0] {IDLE, CMP, TGT, RDR} state_t;

   localparam logic [N-1:0] PC_INC_N = N'(PC_INC);

   state_t         state, state_nxt;
   logic [2:0]     f3_q;
   logic [N-1:0]   rs1_q, rs2_q, pc_q, imm_q, pc_next_q;
   logic           taken_q, illegal_q;
   logic           accept, is_illegal, cmp_taken;

   assign accept     = brValid && (state == IDLE);
   // funct3 010/011 have no branch meaning
   assign is_illegal = (funct3[2:1] == 2'b01);
   assign pcNext     = pc_next_q;

   // Branch decision from the ALU result: equality flag for BEQ/BNE,
   // the SLT/SLTU bit for the ordered compares (odd funct3 inverts the sense).
   always_comb begin
      cmp_taken = 1'b0;
      if (!f3_q[2])
         cmp_taken = aluEqual ^ f3_q[0];
      else if (!f3_q[0])
         cmp_taken = (aluOut == N'(1));
      else
         cmp_taken = (aluOut == '0);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and outputs; ALU outputs stay zero unless requesting
   always_comb begin
      state_nxt = state;
      brReady   = 1'b0;
      aluReq    = 1'b0;
      aluOp     = 2'b00;
      aluOpA    = '0;
      aluOpB    = '0;
      pcLoad    = 1'b0;
      taken     = 1'b0;
      flush     = 1'b0;
      brIllegal = 1'b0;
      case (state)
         IDLE: begin
            brReady = 1'b1;
            if (brValid) state_nxt = is_illegal ? RDR : CMP;
         end
         CMP: begin
            aluReq = 1'b1;
            aluOp  = f3_q[2] ? (f3_q[1] ? 2'b11 : 2'b10) : 2'b01;
            aluOpA = rs1_q;
            aluOpB = rs2_q;
            if (aluGnt) state_nxt = cmp_taken ? TGT : RDR;
         end
         TGT: begin
            aluReq = 1'b1;
            aluOp  = 2'b00;
            aluOpA = pc_q;
            aluOpB = imm_q;
            if (aluGnt) state_nxt = RDR;
         end
         RDR: begin
            pcLoad    = 1'b1;
            taken     = taken_q;
            flush     = taken_q;
            brIllegal = illegal_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept; decision and redirect target capture on grants
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         pc_next_q <= '0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (accept) begin
            f3_q      <= funct3;
            rs1_q     <= rs1Val;
            rs2_q     <= rs2Val;
            pc_q      <= pcIn;
            imm_q     <= immIn;
            taken_q   <= 1'b0;
            illegal_q <= is_illegal;
            // illegal branches skip the ALU and fall through
            if (is_illegal) pc_next_q <= pcIn + PC_INC_N;
         end
         if (state == CMP && aluGnt) begin
            taken_q <= cmp_taken;
            if (!cmp_taken) pc_next_q <= pc_q + PC_INC_N;
         end
         if (state == TGT && aluGnt) pc_next_q <= aluOut;
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating outcome counters; clear has priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brTakenCnt    <= '0;
         brNotTakenCnt <= '0;
      end else if (statsClr) begin
         brTakenCnt    <= '0;
         brNotTakenCnt <= '0;
      end else if (pcLoad) begin
         if (taken) begin
            if (brTakenCnt != '1) brTakenCnt <= brTakenCnt + 32'd1;
         end else begin
            if (brNotTakenCnt != '1) brNotTakenCnt <= brNotTakenCnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: a simple ALU stand-in, a transaction-level model
// (how many ALU borrows a branch needs and where it must land) checked every
// cycle, and directed branches with literal latency/target expectations.
module tb_branch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        brValid, brReady;
   logic [2:0]  funct3;
   logic [31:0] rs1Val, rs2Val, pcIn, immIn;
   logic        aluReq, aluGnt;
   logic [1:0]  aluOp;
   logic [31:0] aluOpA, aluOpB, aluOut;
   logic        aluEqual;
   logic        pcLoad;
   logic [31:0] pcNext;
   logic        taken, flush, brIllegal;
`ifdef BRANCH_STATS_EN
   logic        statsClr = 1'b0;
   logic [31:0] brTakenCnt, brNotTakenCnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   branch_sequencer #(.N(32), .PC_INC(4)) dut (
      .clk(clk), .rst_n(rst_n), .brValid(brValid), .brReady(brReady),
      .funct3(funct3), .rs1Val(rs1Val), .rs2Val(rs2Val), .pcIn(pcIn),
      .immIn(immIn), .aluReq(aluReq), .aluGnt(aluGnt), .aluOp(aluOp),
      .aluOpA(aluOpA), .aluOpB(aluOpB), .aluOut(aluOut), .aluEqual(aluEqual),
`ifdef BRANCH_STATS_EN
      .statsClr(statsClr), .brTakenCnt(brTakenCnt), .brNotTakenCnt(brNotTakenCnt),
`endif
      .pcLoad(pcLoad), .pcNext(pcNext), .taken(taken), .flush(flush),
      .brIllegal(brIllegal)
   );

   // Shared ALU stand-in: result valid in the grant cycle
   always_comb begin
      case (aluOp)
         2'b00:   aluOut = aluOpA + aluOpB;
         2'b01:   aluOut = aluOpA - aluOpB;
         2'b10:   aluOut = 32'($signed(aluOpA) < $signed(aluOpB));
         default: aluOut = 32'(aluOpA < aluOpB);
      endcase
      aluEqual = (aluOpA == aluOpB);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic decide(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Model: a branch needs 0 (illegal), 1 (not taken) or 2 (taken) ALU borrows,
   // each completed by a grant, then one redirect cycle.
   logic        m_busy = 1'b0;
   int          m_left = 0, m_use = 0;
   logic [2:0]  m_f3;
   logic [31:0] m_a, m_b, m_pc, m_imm, m_pcn;
   logic        m_tk, m_ill;
   // observations of the last redirect, for the literal checks
   int          acc_cyc = 0, pl_cyc = 0, pl_cnt = 0, req_cnt = 0;
   logic [31:0] pl_pcn;
   logic        pl_tk, pl_fl, pl_ill;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         chk("rst aluReq", 32'(aluReq), 0);
         chk("rst pcLoad", 32'(pcLoad), 0);
         chk("rst pcNext", pcNext, 0);
         chk("rst taken", 32'(taken), 0);
         chk("rst flush", 32'(flush), 0);
         chk("rst brIllegal", 32'(brIllegal), 0);
         chk("rst aluOpA", aluOpA, 0);
         chk("rst aluOpB", aluOpB, 0);
         chk("rst aluOp", 32'(aluOp), 0);
      end else begin
         logic [31:0] eA, eB;
         logic [1:0]  eOp;
         logic        eReq, eLd;
         eReq = m_busy && (m_left > 0);
         eLd  = m_busy && (m_left == 0);
         eA = 0; eB = 0; eOp = 0;
         if (eReq && m_use == 0) begin
            eA = m_a; eB = m_b;
            eOp = (m_f3[2] == 1'b0) ? 2'd1 : (m_f3[1] ? 2'd3 : 2'd2);
         end else if (eReq) begin
            eA = m_pc; eB = m_imm; eOp = 2'd0;
         end
         chk("brReady", 32'(brReady), 32'(!m_busy));
         chk("aluReq", 32'(aluReq), 32'(eReq));
         chk("aluOp", 32'(aluOp), 32'(eOp));
         chk("aluOpA", aluOpA, eA);
         chk("aluOpB", aluOpB, eB);
         chk("pcLoad", 32'(pcLoad), 32'(eLd));
         chk("taken", 32'(taken), 32'(eLd && m_tk));
         chk("flush", 32'(flush), 32'(eLd && m_tk));
         chk("brIllegal", 32'(brIllegal), 32'(eLd && m_ill));
         if (eLd) chk("pcNext", pcNext, m_pcn);
         if (aluReq) req_cnt++;
         if (pcLoad) begin
            pl_cyc = cyc; pl_pcn = pcNext; pl_tk = taken; pl_fl = flush;
            pl_ill = brIllegal; pl_cnt++;
         end
         // advance to what the next edge does
         if (!m_busy) begin
            if (brValid) begin
               m_busy = 1'b1; m_use = 0; acc_cyc = cyc; req_cnt = 0;
               m_f3 = funct3; m_a = rs1Val; m_b = rs2Val; m_pc = pcIn; m_imm = immIn;
               m_ill = (funct3 == 3'd2) || (funct3 == 3'd3);
               m_tk  = !m_ill && decide(funct3, rs1Val, rs2Val);
               m_pcn = m_tk ? pcIn + immIn : pcIn + 32'd4;
               m_left = m_ill ? 0 : (m_tk ? 2 : 1);
            end
         end else if (m_left > 0) begin
            if (aluGnt) begin m_left--; m_use++; end
         end else begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic scramble();
      funct3 = 3'($urandom); rs1Val = $urandom; rs2Val = $urandom;
      pcIn = $urandom; immIn = $urandom;
   endtask

   // Issue one branch (DUT idle, called at posedge+1); hold = grant-low cycles in CMP
   task automatic branch(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input int hold, input int exp_lat, input logic [31:0] exp_pcn,
                         input logic exp_tk, input logic exp_ill);
      int c0;
      c0 = pl_cnt;
      aluGnt = (hold == 0);
      brValid = 1'b1; funct3 = f3; rs1Val = a; rs2Val = b; pcIn = pc; immIn = imm;
      @(posedge clk); #1;
      brValid = (hold > 0); // must be ignored while busy
      scramble();
      repeat (hold) begin @(posedge clk); #1; scramble(); end
      brValid = 1'b0;
      aluGnt = 1'b1;
      for (int i = 0; i < 40 && pl_cnt == c0; i++) @(posedge clk);
      #1;
      chk({nm, " done"}, 32'(pl_cnt - c0), 1);
      chk({nm, " latency"}, 32'(pl_cyc - acc_cyc), 32'(exp_lat));
      chk({nm, " pcNext"}, pl_pcn, exp_pcn);
      chk({nm, " taken"}, 32'(pl_tk), 32'(exp_tk));
      chk({nm, " flush"}, 32'(pl_fl), 32'(exp_tk));
      chk({nm, " brIllegal"}, 32'(pl_ill), 32'(exp_ill));
   endtask

   initial begin
      int c0;
      rst_n = 1'b0; brValid = 1'b0; aluGnt = 1'b0;
      funct3 = 0; rs1Val = 0; rs2Val = 0; pcIn = 0; immIn = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset brReady", 32'(brReady), 1);
      chk("reset pcLoad", 32'(pcLoad), 0);
      @(posedge clk); #1;

      branch("BEQ taken",  3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 3, 32'h120, 1, 0);
      branch("BNE ntaken", 3'd1, 32'd5, 32'd5, 32'h100, 32'h20, 0, 2, 32'h104, 0, 0);
      chk("BNE aluReq cycles", 32'(req_cnt), 1);
      branch("BLT signed", 3'd4, 32'hFFFFFFFF, 32'd1, 32'h200, 32'hFFFFFFF0, 0, 3, 32'h1F0, 1, 0);
      branch("BLTU", 3'd6, 32'hFFFFFFFF, 32'd1, 32'h200, 32'hFFFFFFF0, 0, 2, 32'h204, 0, 0);
      branch("BGE stall", 3'd5, 32'd7, 32'd3, 32'h300, 32'h40, 5, 8, 32'h340, 1, 0);
      chk("BGE stall aluReq cycles", 32'(req_cnt), 7);
      branch("illegal 010", 3'd2, 32'd1, 32'd1, 32'h500, 32'h8, 0, 1, 32'h504, 0, 1);
      chk("illegal aluReq cycles", 32'(req_cnt), 0);
      branch("BGEU ntaken", 3'd7, 32'd2, 32'd9, 32'h600, 32'h10, 2, 4, 32'h604, 0, 0);
      branch("BNE taken", 3'd1, 32'd1, 32'd2, 32'h10, 32'hFFFFFFF0, 1, 4, 32'h0, 1, 0);

      // reset while the target add is pending
      c0 = pl_cnt;
      aluGnt = 1'b1;
      brValid = 1'b1; funct3 = 3'd0; rs1Val = 3; rs2Val = 3; pcIn = 32'h400; immIn = 8;
      @(posedge clk); #1;               // CMP, granted
      brValid = 1'b0;
      @(posedge clk); #1;               // TGT
      aluGnt = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; aluGnt = 1'b1;
      chk("post-reset brReady", 32'(brReady), 1);
      @(posedge clk); #1;
      chk("reset abort no pcLoad", 32'(pl_cnt - c0), 0);

      branch("wrap", 3'd0, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h4, 0, 2, 32'h0, 0, 0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle controller that resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) on the core's single shared ALU. It borrows the ALU twice per taken branch: once for the compare, once for the target add (pc+imm). It then issues a one-cycle PC redirect and a fetch flush. It sits between decode and the PC register, and its ALU port goes through the existing ALU arbiter.

Parameters:
N, 32, datapath/bus width
PC_INC, 4, not-taken PC increment

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
brValid  in  1  decode presents a branch
brReady  out  1  sequencer can accept a branch (high only in IDLE)
funct3  in  3  branch funct3 field
rs1Val  in  N  operand A
rs2Val  in  N  operand B
pcIn  in  N  PC of the branch instruction
immIn  in  N  sign-extended B-immediate
aluReq  out  1  request for the shared ALU
aluGnt  in  1  grant; ALU result is valid in the same cycle
aluOp  out  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU
aluOpA  out  N  ALU operand A
aluOpB  out  N  ALU operand B
aluOut  in  N  ALU result
aluEqual  in  1  ALU equality flag
pcLoad  out  1  one-cycle PC load strobe
pcNext  out  N  PC value to load; valid while pcLoad is high
taken  out  1  qualifies pcLoad: branch was taken
flush  out  1  one-cycle fetch/decode flush; only on a taken branch
brIllegal  out  1  one-cycle pulse for an unsupported funct3 (010, 011)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. brReady=1 once reset is released; every other output is 0, including the registered operand and pcNext values.
- Accept: in IDLE, brValid & brReady latches funct3, rs1Val, rs2Val, pcIn and immIn. Later changes on these inputs are ignored until the next accept.
- FSM states:
  - IDLE -> CMP on accept.
  - IDLE -> RDR on accept with illegal funct3. No ALU use; the branch is treated as not taken and brIllegal pulses in the RDR cycle.
  - CMP: aluReq=1, aluOpA=rs1, aluOpB=rs2. aluOp is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU. Hold every ALU output stable until aluGnt.
  - On aluGnt in CMP, the decision is captured that cycle:
    - BEQ: aluEqual. BNE: ~aluEqual.
    - BLT/BLTU: aluOut==1. BGE/BGEU: aluOut==0.
    - Taken -> TGT. Not taken -> RDR, with pcNext=pc+PC_INC computed locally, modulo 2^N.
  - TGT: aluReq=1, aluOp=ADD, A=pc, B=imm. On aluGnt, capture aluOut as pcNext -> RDR.
  - RDR: pcLoad=1. taken and flush reflect the decision; flush is 0 when not taken. Then -> IDLE.
- aluReq drops in the cycle after the grant.
- aluOpA/aluOpB/aluOp are 0 whenever aluReq=0.
- Latency, with the grant available immediately (accept at cycle T):
  - taken: pcLoad at T+3
  - not taken: pcLoad at T+2
  - illegal: pcLoad at T+1
- Each cycle without a grant adds one cycle; aluGnt may stay low indefinitely.
- aluGnt is ignored outside CMP/TGT.
- brValid is ignored outside IDLE. A new branch can be accepted in the cycle after RDR.
- Reset mid-operation aborts the branch with no pcLoad. The next branch starts fresh.
- Address arithmetic wraps modulo 2^N; there is no overflow flag.

Optional Feature:
BRANCH_STATS_EN.
- Defined: adds two 32-bit saturating counters, brTakenCnt and brNotTakenCnt, as output ports. Each increments on pcLoad according to taken; illegal branches count as not taken. Both reset to 0 and have a synchronous clear input statsClr, where statsClr wins over increment.
- Undefined: no counters, no extra ports, and behaviour is otherwise identical.

Test Plan:
- BEQ, rs1=5, rs2=5, pc=0x100, imm=0x20, aluGnt tied high -> pcLoad at T+3 with pcNext=0x120, taken=1, flush=1.
- BNE, rs1=5, rs2=5, pc=0x100 -> pcLoad at T+2 with pcNext=0x104, taken=0, flush=0; aluReq high for exactly one cycle.
- BLT, rs1=0xFFFFFFFF, rs2=1 (ALU SLT returns 1) -> taken. BLTU with the same operands (ALU SLTU returns 0) -> not taken, pcNext=pc+4.
- BGE with aluGnt held low 5 cycles in CMP -> aluReq and operands stable throughout, brReady=0, pcLoad at T+8.
- funct3=010 -> no aluReq; brIllegal=1, pcLoad=1, taken=0 at T+1.
- rst_n pulsed low during TGT -> no pcLoad, brReady=1 after release; pc=0xFFFFFFFC not taken -> pcNext=0x00000000.
